mm2s_requant_pp: RTL and testbench

Result drain stage for the systolic matrix-multiply engine. It accepts one column of N1 accumulator lanes per valid cycle and buffers the columns in an internal FIFO. It serialises them onto a single AXI-stream master. Mode 0 emits raw 32-bit accumulators. Mode 1 requantises each lane to int8 using a scale and shift, then packs four lanes per beat. This is the parametrised successor of the fixed 32-bit drain: it adds requantisation, backpressure toward the array, overflow detection and a programmable transfer length.

---
 rtl/mm2s_requant_pp_if.sv | 24 ++
 rtl/mm2s_requant_pp.sv | 176 +++++++++++++++++
 tb/tb_mm2s_requant_pp.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm2s_requant_pp_if.sv
// Column input stream and AXI-stream output of the systolic result drain.
// The master modport is the drain itself; slave is the array/sink side.
interface mm2s_requant_pp_if #(
  parameter int unsigned N1      = 4,
  parameter int unsigned D_W_ACC = 32
);
  logic [N1*D_W_ACC-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    input  in_data, in_valid, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output in_data, in_valid, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/mm2s_requant_pp.sv
// Result drain: buffers accumulator columns, optionally requantises them to
// int8, and serialises them onto a 32-bit AXI-stream master.
module mm2s_requant_pp #(
  parameter int unsigned D_W_ACC      = 32,
  parameter int unsigned N1           = 4,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned MATRIXSIZE_W = 24,
  parameter int unsigned SCALE_W      = 16,
  parameter int unsigned SHIFT_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_mode,
  input  logic [MATRIXSIZE_W-1:0] cfg_cols,
  input  logic [SCALE_W-1:0]      cfg_scale,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  mm2s_requant_pp_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);
  localparam int unsigned PW = D_W_ACC + SCALE_W + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(N1);
  localparam int unsigned TW = MATRIXSIZE_W + BW + 1;
  localparam int unsigned EW = N1 * 32;
  localparam logic signed [PW:0] SAT_HI = 127;
  localparam logic signed [PW:0] SAT_LO = -128;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (N1 % 4 != 0) begin : g_chk_n1
    $error("mm2s_requant_pp: N1 must be a multiple of 4");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("mm2s_requant_pp: FIFO_DEPTH must be a power of two >= 4");
  end

  logic [1:0]              state_q, state_d;
  logic                    mode_q, ovf_q;
  logic [MATRIXSIZE_W-1:0] cols_q, acc_cols_q;
  logic [SCALE_W-1:0]      scale_q, scale_eff;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    s1_vld_q, s2_vld_q;
  logic signed [PW-1:0]    s1_prod_q [N1];
  logic signed [PW-1:0]    prod_d [N1];
  logic [EW-1:0]           s2_entry_q, entry_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             cnt_q;
  logic [AW+1:0]           occ;
  logic [BW-1:0]           beat_q;
  logic [TW-1:0]           emit_q, total_beats;
  logic [31:0]             tdata_q, tdata_d;
  logic                    tvalid_q, tlast_q;
  logic                    run, in_ready, accept, out_free, load;
  logic                    entry_last, push, pop, last_hs;

  assign run         = (state_q == S_RUN);
  assign occ         = {1'b0, cnt_q} + (AW+2)'(s1_vld_q) + (AW+2)'(s2_vld_q);
  assign in_ready    = run && (occ < (AW+2)'(FIFO_DEPTH)) && (acc_cols_q < cols_q);
  assign accept      = bus.in_valid && in_ready;
  assign total_beats = mode_q ? TW'(cols_q) * TW'(N1 / 4) : TW'(cols_q) * TW'(N1);
  assign out_free    = !tvalid_q || bus.m_axis_tready;
  assign load        = run && out_free && (cnt_q != '0);
  assign entry_last  = (beat_q == (mode_q ? BW'(N1 / 4 - 1) : BW'(N1 - 1)));
  assign push        = s2_vld_q;
  assign pop         = load && entry_last;
  assign last_hs     = tvalid_q && bus.m_axis_tready && tlast_q;

  // Mode 0 reuses the multiplier with a unit scale, so the raw lane rides the same pipe.
  always_comb begin
    scale_eff = mode_q ? scale_q : SCALE_W'(1);
    entry_d   = '0;
    for (int unsigned k = 0; k < N1; k++) begin
      logic signed [D_W_ACC-1:0] a;
      logic signed [PW:0]        rnd, sum, shr;
      logic [7:0]                q8;
      a         = bus.in_data[k*D_W_ACC +: D_W_ACC];
      prod_d[k] = PW'(a) * PW'(signed'({1'b0, scale_eff}));
      rnd       = (shift_q != '0) ? ((PW+1)'(1) << (shift_q - SHIFT_W'(1))) : '0;
      sum       = (PW+1)'(s1_prod_q[k]) + rnd;
      shr       = sum >>> shift_q;
      q8        = (shr > SAT_HI) ? 8'h7F : (shr < SAT_LO) ? 8'h80 : shr[7:0];
      entry_d[k*32 +: 32] = mode_q ? {{24{q8[7]}}, q8} : 32'(s1_prod_q[k]);
    end
  end

  always_comb begin
    tdata_d = '0;
    if (mode_q) begin
      for (int unsigned j = 0; j < 4; j++)
        tdata_d[j*8 +: 8] = mem_q[rd_ptr_q][(32'(beat_q)*4 + j)*32 +: 8];
    end else begin
      tdata_d = mem_q[rd_ptr_q][32'(beat_q)*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N1; k++) s1_prod_q[k] <= prod_d[k];
    s2_entry_q <= entry_d;
    if (push) mem_q[wr_ptr_q] <= s2_entry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      cols_q     <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      acc_cols_q <= '0;
      ovf_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      emit_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (state_q == S_IDLE && start) begin
        mode_q     <= cfg_mode;
        cols_q     <= cfg_cols;
        scale_q    <= cfg_scale;
        shift_q    <= cfg_shift;
        acc_cols_q <= '0;
        ovf_q      <= 1'b0;
        beat_q     <= '0;
        emit_q     <= '0;
      end
      if (accept) acc_cols_q <= acc_cols_q + MATRIXSIZE_W'(1);
      if (run && bus.in_valid && !in_ready && acc_cols_q < cols_q) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      if (load) begin
        tdata_q  <= tdata_d;
        tvalid_q <= 1'b1;
        tlast_q  <= (emit_q == total_beats - TW'(1));
        emit_q   <= emit_q + TW'(1);
        beat_q   <= entry_last ? '0 : beat_q + BW'(1);
      end else if (out_free) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign busy              = run;
  assign done              = (state_q == S_DONE);
  assign overflow          = ovf_q;
endmodule

// File: tb/tb_mm2s_requant_pp.sv
// Scoreboard bench for mm2s_requant_pp: directed columns push hand-computed
// beats; an independent monitor pops and compares on every AXIS handshake.
module tb_mm2s_requant_pp;
  localparam int unsigned N1 = 4;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst, start, cfg_mode;
  logic [23:0] cfg_cols;
  logic [15:0] cfg_scale;
  logic [5:0]  cfg_shift;
  logic        busy, done, overflow;

  mm2s_requant_pp_if #(.N1(N1), .D_W_ACC(DW)) bus ();

  mm2s_requant_pp #(
    .D_W_ACC(DW), .N1(N1), .FIFO_DEPTH(4), .MATRIXSIZE_W(24), .SCALE_W(16), .SHIFT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_cols(cfg_cols),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic l; } beat_t;
  beat_t sbq[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, hs_cnt = 0, tlast_cnt = 0, last_hs_cyc = 0;
  int exp_total = 0, exp_pushed = 0, acc_cnt = 0, rdy_mode = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [127:0] mkcol(int a0, int a1, int a2, int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(1, 0) == 1);
    end
  end

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  initial begin
    logic        hold_v;
    logic [31:0] hold_d;
    logic        hold_l;
    beat_t       e;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
          chk("stall_tdata", bus.m_axis_tdata, hold_d);
          chk("stall_tlast", 32'(bus.m_axis_tlast), 32'(hold_l));
        end
        hold_v = bus.m_axis_tvalid && !bus.m_axis_tready;
        hold_d = bus.m_axis_tdata;
        hold_l = bus.m_axis_tlast;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          hs_cnt++;
          if (bus.m_axis_tlast) begin
            tlast_cnt++;
            last_hs_cyc = cyc;
          end
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got 0x%08h expected no beat (cycle %0d)",
                     bus.m_axis_tdata, cyc);
          end else begin
            e = sbq.pop_front();
            chk("beat_tdata", bus.m_axis_tdata, e.d);
            chk("beat_tlast", 32'(bus.m_axis_tlast), 32'(e.l));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic begin_xfer(logic mode, int cols, int scale, int shift);
    cfg_mode  = mode;
    cfg_cols  = 24'(cols);
    cfg_scale = 16'(scale);
    cfg_shift = 6'(shift);
    exp_total = cols * (mode ? N1 / 4 : N1);
    exp_pushed = 0;
    hs_cnt = 0;
    tlast_cnt = 0;
    acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode  = ~mode;
    cfg_cols  = 24'hFFFFFF;
    cfg_scale = 16'h7777;
    cfg_shift = 6'd9;
  endtask

  task automatic push_exp(logic [31:0] d);
    beat_t b;
    exp_pushed++;
    b.d = d;
    b.l = (exp_pushed == exp_total);
    sbq.push_back(b);
  endtask

  task automatic send_col(logic [127:0] col, int budget);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = col;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (ok) acc_cnt++;
    else begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", budget);
    end
  endtask

  task automatic wait_done(int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("done_after_last", 32'(cyc), 32'(last_hs_cyc + 1));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("tlast_count", 32'(tlast_cnt), 32'd1);
        chk("beat_count", 32'(hs_cnt), 32'(exp_total));
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got done=0 for %0d cycles expected a pulse", budget);
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    cfg_mode = 1'b0;
    cfg_cols = '0;
    cfg_scale = '0;
    cfg_shift = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    do_reset();

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();

    // Raw mode, two columns; scale must have no effect.
    rdy_mode = 1;
    begin_xfer(1'b0, 2, 5, 3);
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    tick();
    push_exp(32'd1); push_exp(32'hFFFF_FFFE); push_exp(32'd3); push_exp(32'hFFFF_FFFC);
    push_exp(32'd5); push_exp(32'd6); push_exp(32'd7); push_exp(32'd8);
    send_col(mkcol(1, -2, 3, -4), 20);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk("first_tvalid_latency", 32'(bus.m_axis_tvalid), 32'(n == 4));
    end
    tick();
    send_col(mkcol(5, 6, 7, 8), 20);
    bus.in_valid = 1'b1;
    bus.in_data = mkcol(99, 99, 99, 99);
    repeat (3) tick();
    @(negedge clk);
    chk("beyond_cols_in_ready", 32'(bus.in_ready), 32'd0);
    chk("beyond_cols_overflow", 32'(overflow), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    wait_done(60);

    // Requant with rounding and saturation in both directions.
    begin_xfer(1'b1, 1, 3, 2);
    push_exp(32'h807F_F908);
    send_col(mkcol(10, -10, 1000, -1000), 20);
    wait_done(60);

    begin_xfer(1'b1, 1, 1, 0);
    push_exp(32'h8080_7F7F);
    send_col(mkcol(127, 128, -128, -129), 20);
    wait_done(60);

    // Backpressure: sink stalled for 40 cycles with continuous input.
    rdy_mode = 0;
    begin_xfer(1'b0, 8, 1, 0);
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 4; k++) push_exp(32'(100 + 4 * j + k));
    fork
      begin
        for (int j = 0; j < 8; j++)
          send_col(mkcol(100 + 4 * j, 101 + 4 * j, 102 + 4 * j, 103 + 4 * j), 200);
      end
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted_cols", 32'(acc_cnt), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        tick();
        rdy_mode = 1;
      end
    join
    wait_done(200);

    // Random sink stalls and input gaps; scale 2 / shift 1 is an identity.
    rdy_mode = 2;
    begin_xfer(1'b1, 100, 2, 1);
    @(negedge clk);
    chk("start_clears_overflow", 32'(overflow), 32'd0);
    tick();
    for (int i = 0; i < 100; i++) begin
      push_exp({8'(7), 8'(i - 50), 8'(-i), 8'(i)});
      repeat ($urandom_range(2, 0)) tick();
      send_col(mkcol(i, -i, i - 50, 7), 100);
    end
    wait_done(1000);

    // Reset in the middle of a transfer, then a clean one-column transfer.
    rdy_mode = 1;
    begin_xfer(1'b0, 4, 1, 0);
    for (int k = 0; k < 8; k++) push_exp(32'(200 + k));
    send_col(mkcol(200, 201, 202, 203), 20);
    send_col(mkcol(204, 205, 206, 207), 20);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (hs_cnt >= 3) hit = 1'b1;
      else tick();
    end
    chk("rst_mid_reached_3_beats", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    tick();
    sbq.delete();
    rst = 1'b0;
    tick();
    begin_xfer(1'b0, 1, 1, 0);
    push_exp(32'd11); push_exp(32'd22); push_exp(32'd33); push_exp(32'd44);
    send_col(mkcol(11, 22, 33, 44), 20);
    wait_done(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
